// File: rtl/io_intc_port.sv
// Memory-mapped I/O port: word RAM window on a shared tri-state bus plus a small
// interrupt controller (pending / mask / vector / control) driving one CPU interrupt.
module io_intc_port #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 512,
   parameter int NUM_CH = 4
) (
   input  logic              Clk,
   input  logic              Rst_,
   input  logic [ADDR_W-1:0] Addr,
   inout  wire  [DATA_W-1:0] Data,
   input  logic              IO_CS_,
   input  logic              IO_RD_,
   input  logic              IO_WR_,
   input  logic [NUM_CH-1:0] ev_in,
   input  logic              int_ack,
   output logic              interrupt
);

   localparam int REG_BASE = 2**ADDR_W - 4;
   localparam int VEC_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ADDR_W-1:0] A_DEPTH = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] A_PEND  = ADDR_W'(REG_BASE);
   localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'(REG_BASE + 1);
   localparam logic [ADDR_W-1:0] A_VEC   = ADDR_W'(REG_BASE + 2);
   localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(REG_BASE + 3);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_en, rd_en, ram_hit;
   logic [RAM_AW-1:0] ram_idx;
   logic [NUM_CH-1:0] pend_q, pend_d, mask_q, mask_d, ev_q, ev_d;
   logic [NUM_CH-1:0] rise, clr, hits;
   logic              gie_q, gie_d, irq_q, irq_d;
   logic              vec_valid;
   logic [VEC_W-1:0]  vec_idx;
   logic [DATA_W-1:0] rd_data;

   assign wr_en   = !IO_CS_ && !IO_WR_;
   // A write strobe wins over a simultaneous read strobe: the bus is never driven then.
   assign rd_en   = !IO_CS_ && !IO_RD_ && IO_WR_;
   assign ram_hit = (Addr < A_DEPTH);
   assign ram_idx = Addr[RAM_AW-1:0];
   assign hits    = pend_q & mask_q;

   // Lowest enabled pending channel has priority.
   always_comb begin
      vec_valid = 1'b0;
      vec_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hits[i]) begin
            vec_valid = 1'b1;
            vec_idx   = VEC_W'(i);
         end
      end
   end

   always_comb begin
      rise = ev_in & ~ev_q;
      clr  = '0;
      if (wr_en && Addr == A_PEND) clr = Data[NUM_CH-1:0];
      if (int_ack && vec_valid)    clr[vec_idx] = 1'b1;
      // A fresh edge outranks any clear in the same cycle.
      pend_d = (pend_q & ~clr) | rise;
      mask_d = mask_q;
      if (wr_en && Addr == A_MASK) mask_d = Data[NUM_CH-1:0];
      gie_d = gie_q;
      if (wr_en && Addr == A_CTRL) gie_d = Data[0];
      ev_d  = ev_in;
      irq_d = gie_q & (|hits);
   end

   always_ff @(posedge Clk or negedge Rst_) begin
      if (!Rst_) begin
         pend_q <= '0;
         mask_q <= '0;
         gie_q  <= 1'b0;
         ev_q   <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         mask_q <= mask_d;
         gie_q  <= gie_d;
         ev_q   <= ev_d;
         irq_q  <= irq_d;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge Clk) begin
      if (wr_en && ram_hit) mem[ram_idx] <= Data;
   end

   always_comb begin
      rd_data = '0;
      if (ram_hit) begin
         rd_data = mem[ram_idx];
      end else begin
         case (Addr)
            A_PEND: rd_data[NUM_CH-1:0] = pend_q;
            A_MASK: rd_data[NUM_CH-1:0] = mask_q;
            A_VEC: begin
               rd_data[DATA_W-1]  = vec_valid;
               rd_data[VEC_W-1:0] = vec_idx;
            end
            A_CTRL: rd_data[0] = gie_q;
            default: ;
         endcase
      end
   end

   assign Data      = rd_en ? rd_data : {DATA_W{1'bz}};
   assign interrupt = irq_q;

endmodule

// File: tb/tb_io_intc_port.sv
// Bench for io_intc_port: directed scenarios plus a randomized run checked
// against a behavioural model of the register map and interrupt rules.
module tb_io_intc_port;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 512;
   localparam int NUM_CH = 4;
   localparam int RAM_AW = 9;
   localparam logic [ADDR_W-1:0] REG = 10'd1020;

   logic              Clk = 1'b0;
   logic              Rst_ = 1'b0;
   logic [ADDR_W-1:0] Addr = '0;
   wire  [DATA_W-1:0] Data;
   logic [DATA_W-1:0] wdata = '0;
   logic              drv = 1'b0;
   logic              IO_CS_ = 1'b1, IO_RD_ = 1'b1, IO_WR_ = 1'b1;
   logic [NUM_CH-1:0] ev_in = '0;
   logic              int_ack = 1'b0;
   logic              interrupt;

   int checks = 0;
   int errors = 0;

   assign Data = drv ? wdata : {DATA_W{1'bz}};

   io_intc_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
      .Clk(Clk), .Rst_(Rst_), .Addr(Addr), .Data(Data), .IO_CS_(IO_CS_), .IO_RD_(IO_RD_),
      .IO_WR_(IO_WR_), .ev_in(ev_in), .int_ack(int_ack), .interrupt(interrupt)
   );

   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   logic [NUM_CH-1:0] m_pend, m_mask, m_prev_ev;
   logic              m_gie, m_irq;
   logic [DATA_W-1:0] m_ram [DEPTH];
   bit                m_known [DEPTH];

   function automatic bit m_wr();
      return !IO_CS_ && !IO_WR_;
   endfunction

   function automatic logic [NUM_CH-1:0] m_w1c();
      return (m_wr() && Addr == REG) ? Data[NUM_CH-1:0] : '0;
   endfunction

   // Lowest set bit of the enabled-pending set, isolated arithmetically.
   function automatic logic [NUM_CH-1:0] m_ackbit();
      logic [NUM_CH-1:0] h;
      h = m_pend & m_mask;
      return int_ack ? (h & (~h + 1'b1)) : '0;
   endfunction

   function automatic logic [DATA_W-1:0] m_vec();
      logic [NUM_CH-1:0] h;
      h = m_pend & m_mask;
      for (int i = 0; i < NUM_CH; i++) if (h[i]) return 32'h8000_0000 | 32'(i);
      return '0;
   endfunction

   function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a, output bit known);
      logic [DATA_W-1:0] v;
      known = 1'b1;
      v = '0;
      if (a < 10'(DEPTH)) begin
         known = m_known[a[RAM_AW-1:0]];
         v = m_ram[a[RAM_AW-1:0]];
      end else if (a == REG)     v = 32'(m_pend);
      else if (a == REG + 10'd1) v = 32'(m_mask);
      else if (a == REG + 10'd2) v = m_vec();
      else if (a == REG + 10'd3) v = {31'b0, m_gie};
      return v;
   endfunction

   always @(posedge Clk or negedge Rst_) begin
      if (!Rst_) begin
         m_pend <= '0; m_mask <= '0; m_gie <= 1'b0; m_prev_ev <= '0; m_irq <= 1'b0;
      end else begin
         m_prev_ev <= ev_in;
         m_irq     <= m_gie && ((m_pend & m_mask) != '0);
         m_pend    <= (m_pend & ~m_w1c() & ~m_ackbit()) | (ev_in & ~m_prev_ev);
         if (m_wr()) begin
            if (Addr < 10'(DEPTH)) begin
               m_ram[Addr[RAM_AW-1:0]]   <= Data;
               m_known[Addr[RAM_AW-1:0]] <= 1'b1;
            end
            if (Addr == REG + 10'd1) m_mask <= Data[NUM_CH-1:0];
            if (Addr == REG + 10'd3) m_gie  <= Data[0];
         end
      end
   end

   // ---------------- bus helpers ----------------
   task automatic step(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [NUM_CH-1:0] ev, input bit ack);
      Addr = a; wdata = d; drv = w; IO_CS_ = ~w; IO_WR_ = ~w; ev_in = ev; int_ack = ack;
      @(posedge Clk); #1;
      drv = 1'b0; IO_CS_ = 1'b1; IO_WR_ = 1'b1; int_ack = 1'b0;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      step(1'b1, a, d, ev_in, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, '0, '0, ev_in, 1'b0);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
      @(negedge Clk);
      drv = 1'b0; Addr = a; IO_CS_ = 1'b0; IO_RD_ = 1'b0; IO_WR_ = 1'b1;
      #2 d = Data;
      #1 IO_CS_ = 1'b1; IO_RD_ = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [DATA_W-1:0] r;
      repeat (2) @(posedge Clk);
      #1;
      if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", interrupt); end checks++;
      for (int i = 0; i < 4; i++) begin
         rd(REG + 10'(i), r);
         if (r !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", i, r); end checks++;
      end
      @(negedge Clk); Rst_ = 1'b1;
   endtask

   task automatic test_ram();
      logic [DATA_W-1:0] r, dv [8];
      wr(10'd5, 32'hDEAD_BEEF);
      rd(10'd5, r);
      if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram5 got=%h exp=deadbeef", r); end checks++;
      // Deselected: the bench drives 0; any DUT contention would corrupt it.
      @(negedge Clk);
      Addr = 10'd5; wdata = '0; drv = 1'b1; IO_CS_ = 1'b1; IO_RD_ = 1'b0;
      #2 if (Data !== 32'h0) begin errors++; $display("FAIL hiz got=%h exp=00000000", Data); end checks++;
      #1 drv = 1'b0; IO_RD_ = 1'b1;
      // RD and WR both low: the write lands and the port stays off the bus.
      IO_RD_ = 1'b0; step(1'b1, 10'd6, 32'hA5A5_0F0F, ev_in, 1'b0); IO_RD_ = 1'b1;
      rd(10'd6, r);
      if (r !== 32'hA5A5_0F0F) begin errors++; $display("FAIL rdwr_both got=%h exp=a5a50f0f", r); end checks++;
      wr(10'(DEPTH + 100), 32'hFFFF_FFFF);
      rd(10'(DEPTH), r);
      if (r !== 32'h0) begin errors++; $display("FAIL unmapped_lo got=%h exp=0", r); end checks++;
      rd(10'(DEPTH + 100), r);
      if (r !== 32'h0) begin errors++; $display("FAIL unmapped_wr got=%h exp=0", r); end checks++;
      for (int i = 0; i < 8; i++) begin
         dv[i] = $urandom;
         wr(10'(8 + i), dv[i]);
      end
      for (int i = 0; i < 8; i++) begin
         rd(10'(8 + i), r);
         if (r !== dv[i]) begin errors++; $display("FAIL ram_rand%0d got=%h exp=%h", i, r, dv[i]); end checks++;
      end
   endtask

   task automatic test_irq();
      logic [DATA_W-1:0] r;
      wr(REG + 10'd1, 32'h4);
      wr(REG + 10'd3, 32'h1);
      step(1'b0, '0, '0, 4'b0100, 1'b0);
      if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", interrupt); end checks++;
      rd(REG, r);
      if (r !== 32'h4) begin errors++; $display("FAIL irq_pend got=%h exp=4", r); end checks++;
      step(1'b0, '0, '0, 4'b0000, 1'b0);
      if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", interrupt); end checks++;
      rd(REG + 10'd2, r);
      if (r !== 32'h8000_0002) begin errors++; $display("FAIL irq_vec got=%h exp=80000002", r); end checks++;
   endtask

   task automatic test_priority_ack();
      logic [DATA_W-1:0] r;
      wr(REG + 10'd1, 32'hF);
      step(1'b0, '0, '0, 4'b0010, 1'b0);
      step(1'b0, '0, '0, 4'b0000, 1'b0);
      rd(REG, r);
      if (r !== 32'h6) begin errors++; $display("FAIL prio_pend got=%h exp=6", r); end checks++;
      rd(REG + 10'd2, r);
      if (r !== 32'h8000_0001) begin errors++; $display("FAIL prio_vec got=%h exp=80000001", r); end checks++;
      step(1'b0, '0, '0, ev_in, 1'b1);
      rd(REG, r);
      if (r !== 32'h4) begin errors++; $display("FAIL ack1_pend got=%h exp=4", r); end checks++;
      rd(REG + 10'd2, r);
      if (r !== 32'h8000_0002) begin errors++; $display("FAIL ack1_vec got=%h exp=80000002", r); end checks++;
      step(1'b0, '0, '0, ev_in, 1'b1);
      if (interrupt !== 1'b1) begin errors++; $display("FAIL ack1_irq got=%b exp=1", interrupt); end checks++;
      rd(REG, r);
      if (r !== 32'h0) begin errors++; $display("FAIL ack2_pend got=%h exp=0", r); end checks++;
      idle();
      if (interrupt !== 1'b0) begin errors++; $display("FAIL ack2_irq got=%b exp=0", interrupt); end checks++;
      step(1'b0, '0, '0, ev_in, 1'b1);
      rd(REG, r);
      if (r !== 32'h0) begin errors++; $display("FAIL ack_none got=%h exp=0", r); end checks++;
   endtask

   task automatic test_collision();
      logic [DATA_W-1:0] r;
      step(1'b0, '0, '0, 4'b0111, 1'b0);
      step(1'b0, '0, '0, 4'b0000, 1'b0);
      step(1'b1, REG, 32'h1, 4'b0001, 1'b1);
      rd(REG, r);
      if (r !== 32'h7) begin errors++; $display("FAIL collide got=%h exp=7", r); end checks++;
      step(1'b1, REG, 32'h4, 4'b0000, 1'b1);
      rd(REG, r);
      if (r !== 32'h2) begin errors++; $display("FAIL w1c_ack got=%h exp=2", r); end checks++;
      wr(REG, 32'hF);
   endtask

   task automatic test_level();
      logic [DATA_W-1:0] r;
      step(1'b0, '0, '0, 4'b0010, 1'b0);
      step(1'b1, REG, 32'h2, 4'b0010, 1'b0);
      repeat (3) idle();
      rd(REG, r);
      if (r !== 32'h0) begin errors++; $display("FAIL level_once got=%h exp=0", r); end checks++;
      step(1'b0, '0, '0, 4'b0000, 1'b0);
      step(1'b0, '0, '0, 4'b0010, 1'b0);
      rd(REG, r);
      if (r !== 32'h2) begin errors++; $display("FAIL level_reedge got=%h exp=2", r); end checks++;
      step(1'b1, REG, 32'hF, 4'b0000, 1'b0);
      idle();
   endtask

   task automatic test_mask_gie();
      logic [DATA_W-1:0] r;
      wr(REG + 10'd1, 32'h0);
      step(1'b0, '0, '0, 4'b1000, 1'b0);
      step(1'b0, '0, '0, 4'b0000, 1'b0);
      idle();
      rd(REG, r);
      if (r !== 32'h8) begin errors++; $display("FAIL masked_pend got=%h exp=8", r); end checks++;
      rd(REG + 10'd2, r);
      if (r !== 32'h0) begin errors++; $display("FAIL masked_vec got=%h exp=0", r); end checks++;
      if (interrupt !== 1'b0) begin errors++; $display("FAIL masked_irq got=%b exp=0", interrupt); end checks++;
      wr(REG + 10'd1, 32'h8);
      idle();
      if (interrupt !== 1'b1) begin errors++; $display("FAIL unmask_irq got=%b exp=1", interrupt); end checks++;
      wr(REG + 10'd3, 32'h0);
      idle();
      if (interrupt !== 1'b0) begin errors++; $display("FAIL gie_off got=%b exp=0", interrupt); end checks++;
      rd(REG + 10'd3, r);
      if (r !== 32'h0) begin errors++; $display("FAIL ctrl_rd got=%h exp=0", r); end checks++;
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] r, e;
      logic [ADDR_W-1:0] a;
      logic [NUM_CH-1:0] ev;
      bit known;
      for (int n = 0; n < 200; n++) begin
         ev = ev_in ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         case ($urandom_range(0, 4))
            0: step(1'b1, 10'($urandom_range(8, 23)), $urandom, ev, 1'b0);
            1: step(1'b1, 10'($urandom_range(DEPTH, 1019)), $urandom, ev, 1'b0);
            2: step(1'b1, REG + 10'($urandom_range(0, 3)), $urandom, ev, $urandom_range(0, 2) == 0);
            default: step(1'b0, '0, '0, ev, $urandom_range(0, 2) == 0);
         endcase
         if (interrupt !== m_irq) begin errors++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, interrupt, m_irq); end checks++;
         case ($urandom_range(0, 2))
            0: a = REG + 10'($urandom_range(0, 3));
            1: a = 10'($urandom_range(8, 23));
            default: a = 10'($urandom_range(DEPTH, 1019));
         endcase
         rd(a, r);
         e = exp_read(a, known);
         if (known) begin
            if (r !== e) begin errors++; $display("FAIL rnd_rd n=%0d addr=%0d got=%h exp=%h", n, a, r, e); end
            checks++;
         end
      end
      step(1'b1, REG, 32'hF, '0, 1'b0);
   endtask

   task automatic test_async_reset();
      logic [DATA_W-1:0] r;
      wr(REG + 10'd1, 32'hF);
      wr(REG + 10'd3, 32'h1);
      step(1'b0, '0, '0, 4'b0001, 1'b0);
      step(1'b0, '0, '0, 4'b0000, 1'b0);
      idle();
      if (interrupt !== 1'b1) begin errors++; $display("FAIL pre_rst_irq got=%b exp=1", interrupt); end checks++;
      @(negedge Clk); #2 Rst_ = 1'b0;
      #1 if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", interrupt); end checks++;
      drv = 1'b0; IO_CS_ = 1'b0; IO_RD_ = 1'b0; IO_WR_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) continue;
         Addr = REG + 10'(i);
         #1 if (Data !== 32'h0) begin errors++; $display("FAIL rst_reg%0d got=%h exp=0", i, Data); end checks++;
      end
      Addr = 10'd5;
      #1 if (Data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_ram5 got=%h exp=deadbeef", Data); end checks++;
      IO_CS_ = 1'b1; IO_RD_ = 1'b1;
      ev_in = 4'b0100;
      repeat (2) @(posedge Clk);
      @(negedge Clk); Rst_ = 1'b1;
      @(posedge Clk); #1;
      rd(REG, r);
      if (r !== 32'h4) begin errors++; $display("FAIL release_edge got=%h exp=4", r); end checks++;
      rd(REG + 10'd1, r);
      if (r !== 32'h0) begin errors++; $display("FAIL release_mask got=%h exp=0", r); end checks++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ram();
      test_irq();
      test_priority_ack();
      test_collision();
      test_level();
      test_mask_gie();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
